core_reg_file: RTL and testbench

- Clocked, parametrised integer register file for the RV32 core.
- Has NRD combinational read ports, one synchronous write port, same-cycle write-to-read bypass, a per-register busy scoreboard, and a registered write-done pulse.
- Sits between decode/issue (reads, busy set) and write-back (writes, busy clear).
- Register 0 is hard-wired to zero and is never busy.

---
 rtl/core_pkg.sv | 14 +
 rtl/core_reg_scoreboard.sv | 35 +++
 rtl/core_reg_file.sv | 88 ++++++++
 tb/tb_core_reg_file.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and word types for the RV32 core register file.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  // Architectural x0; compared after a cast to the local address width.
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/core_reg_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, set wins on collision.
module core_reg_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_busy,
  input  logic [AW-1:0]   set_addr,
  input  logic            wen,
  input  logic [AW-1:0]   rd_addr,
  output logic [NREG-1:0] sb,
  output logic            busy_any
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (set_busy && (set_addr == AW'(r))) begin
          sb[r] <= 1'b1;
        end else if (wen && (rd_addr == AW'(r))) begin
          sb[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_any = |sb;

endmodule

// File: rtl/core_reg_file.sv
// RV32 integer register file: NRD combinational read ports with write bypass,
// one write port, busy scoreboard. Optional debug taps under CORE_REG_FILE_DEBUG_EN.
module core_reg_file
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD*XLEN-1:0]  rs_dout,
  output logic [NRD-1:0]       rs_busy,
  input  logic                 wen,
  input  logic [AW-1:0]        rd_addr,
  input  logic [XLEN-1:0]      rd_din,
  output logic                 done,
  input  logic                 set_busy,
  input  logic [AW-1:0]        set_addr,
`ifdef CORE_REG_FILE_DEBUG_EN
  input  logic [AW-1:0]        dbg_sel,
  output logic [XLEN-1:0]      dbg_dout,
  output logic [31:0]          dbg_wr_cnt,
`endif
  output logic                 busy_any
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] sb;

  // x0 is never written, so its storage stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      done <= 1'b0;
    end else begin
      done <= wen;
      if (wen && (rd_addr != AW'(REG_ZERO))) begin
        regs[rd_addr] <= rd_din;
      end
    end
  end

  core_reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .wen      (wen),
    .rd_addr  (rd_addr),
    .sb       (sb),
    .busy_any (busy_any)
  );

  // A write in flight both forwards its data and releases the hazard.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rs_addr[k*AW +: AW];
    assign hit = wen && (rd_addr == a);
    assign rs_dout[k*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0
                                   : hit                  ? rd_din
                                   :                        regs[a];
    assign rs_busy[k] = sb[a] & ~hit;
  end

`ifdef CORE_REG_FILE_DEBUG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_dout   <= '0;
      dbg_wr_cnt <= '0;
    end else begin
      dbg_dout <= regs[dbg_sel];
      if (wen && (dbg_wr_cnt != 32'hFFFF_FFFF)) begin
        dbg_wr_cnt <= dbg_wr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_reg_file.sv
// Self-checking bench for core_reg_file: directed plan items plus a random phase
// checked against a reference model through an expected-value queue.
module tb_core_reg_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_dout;
  logic [NRD-1:0]      rs_busy;
  logic                wen;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_din;
  logic                done;
  logic                set_busy;
  logic [AW-1:0]       set_addr;
  logic                busy_any;
`ifdef CORE_REG_FILE_DEBUG_EN
  logic [AW-1:0]       dbg_sel = '0;
  logic [XLEN-1:0]     dbg_dout;
  logic [31:0]         dbg_wr_cnt;
`endif

  core_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rs_dout    (rs_dout),
    .rs_busy    (rs_busy),
    .wen        (wen),
    .rd_addr    (rd_addr),
    .rd_din     (rd_din),
    .done       (done),
    .set_busy   (set_busy),
    .set_addr   (set_addr),
`ifdef CORE_REG_FILE_DEBUG_EN
    .dbg_sel    (dbg_sel),
    .dbg_dout   (dbg_dout),
    .dbg_wr_cnt (dbg_wr_cnt),
`endif
    .busy_any   (busy_any)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_sb;
  logic            m_done;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wen && rd_addr == a) return rd_din;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    return m_sb[a] && !(wen && rd_addr == a);
  endfunction

  // Drive one cycle of inputs and queue the expected combinational view.
  task automatic drive(input logic r, input logic w, input logic [AW-1:0] ra,
                       input logic [XLEN-1:0] d, input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rst_n = r; wen = w; rd_addr = ra; rd_din = d;
    set_busy = s; set_addr = sa; rs_addr = {a1, a0};
    exp_q.push_back(m_read(a0));
    exp_q.push_back(m_read(a1));
    exp_q.push_back({31'd0, m_busy(a0)});
    exp_q.push_back({31'd0, m_busy(a1)});
    exp_q.push_back({31'd0, m_done});
    exp_q.push_back({31'd0, |m_sb});
  endtask

  // Compare the queued view, then clock and advance the model.
  task automatic cycle();
    #1;
    check("qdepth", XLEN'(exp_q.size()), 32'd6);
    if (exp_q.size() == 6) begin
      check("dout0",    rs_dout[0 +: XLEN],        exp_q.pop_front());
      check("dout1",    rs_dout[XLEN +: XLEN],     exp_q.pop_front());
      check("busy0",    {31'd0, rs_busy[0]},       exp_q.pop_front());
      check("busy1",    {31'd0, rs_busy[1]},       exp_q.pop_front());
      check("done",     {31'd0, done},             exp_q.pop_front());
      check("busy_any", {31'd0, busy_any},         exp_q.pop_front());
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_sb   = '0;
      m_done = 1'b0;
    end else begin
      m_done = wen;
      if (wen && rd_addr != '0) m_regs[rd_addr] = rd_din;
      for (int r2 = 1; r2 < NREG; r2++) begin
        if (set_busy && set_addr == AW'(r2)) m_sb[r2] = 1'b1;
        else if (wen && rd_addr == AW'(r2)) m_sb[r2] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; rd_addr = '0; rd_din = '0;
    set_busy = 1'b0; set_addr = '0; rs_addr = '0;
    @(posedge clk);
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_sb = '0; m_done = 1'b0;
    #1;

    // reset state, then reset clears data and discards a concurrent write
    drive(1, 0, 0, 0, 0, 0, 5, 0);                  cycle();
    drive(1, 1, 5, 32'hDEADBEEF, 1, 9, 5, 9);       cycle();
    drive(0, 1, 6, 32'h11112222, 1, 6, 5, 6);       cycle();
    drive(1, 0, 0, 0, 0, 0, 5, 6);                  cycle();
    check("x5_after_rst", rs_dout[0 +: XLEN], 32'h0);

    // x0 immutability and done pulse
    drive(1, 1, 0, 32'h12345678, 0, 0, 0, 0);       cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);                  cycle();
    check("done_after_x0", {31'd0, done}, 32'd0);

    // bypass
    drive(1, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);       cycle();
    drive(1, 0, 0, 0, 0, 0, 7, 1);                  cycle();

    // scoreboard set then clear
    drive(1, 0, 0, 0, 1, 3, 3, 0);                  cycle();
    drive(1, 1, 3, 32'h33333333, 0, 0, 3, 3);       cycle();
    drive(1, 0, 0, 0, 1, 0, 3, 0);                  cycle();

    // set/clear collision, set wins
    drive(1, 1, 4, 32'h44444444, 1, 4, 4, 0);       cycle();
    drive(1, 0, 0, 0, 1, 4, 4, 4);                  cycle();

    // back-to-back writes, identical reads on both ports
    drive(1, 1, 1, 32'h01010101, 0, 0, 2, 2);       cycle();
    drive(1, 1, 2, 32'h02020202, 0, 0, 2, 2);       cycle();
    drive(1, 1, 3, 32'h03030303, 0, 0, 2, 2);       cycle();
    drive(1, 0, 0, 0, 0, 0, 2, 2);                  cycle();
    drive(1, 1, 4, 32'h0, 0, 0, 1, 4);              cycle();

    // random traffic on a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)),
            $urandom,
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
